// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers 18-bit instruction words in a small FIFO, decodes them
// into register-file command fields and sequences a fixed multi-cycle write enable.
module instr_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int WE_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] instr_in,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  opcode,
    output logic [3:0]  addr1,
    output logic [3:0]  addr2,
    output logic [3:0]  dest,
    output logic        sinalImm,
    output logic [5:0]  Imm,
    output logic        we,
    output logic        display_en,
    output logic        done,
    output logic        busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int WEC_W = $clog2(WE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [WEC_W-1:0] WEC_ZERO  = {WEC_W{1'b0}};
    localparam logic [WEC_W-1:0] WEC_ONE   = WEC_W'(1);
    localparam logic [WEC_W-1:0] WEC_LAST  = WEC_W'(WE_CYCLES - 1);

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    state_e             state_r;
    state_e             state_next_s;
    logic [17:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic [WEC_W-1:0]   we_cnt_r;
    logic [WEC_W-1:0]   we_cnt_next_s;
    logic               push_s;
    logic               pop_s;
    logic               disp_next_s;

    logic [17:0]        head_s;
    logic [2:0]         dec_opcode_s;
    logic [3:0]         dec_dest_s;
    logic [3:0]         dec_addr1_s;
    logic [3:0]         dec_addr2_s;
    logic               dec_sign_s;
    logic [5:0]         dec_imm_s;

    logic [2:0]         opcode_r;
    logic [3:0]         addr1_r;
    logic [3:0]         addr2_r;
    logic [3:0]         dest_r;
    logic               sign_r;
    logic [5:0]         imm_r;
    logic               we_r;
    logic               display_en_r;
    logic               done_r;
    logic               busy_r;
    logic               ready_r;

    // A push is only taken while not full, and never during reset
    assign push_s = instr_valid && ready_r && !rst;

    // Field decode of the FIFO head; CLEAR and DISPLAY carry the raw low bits apart from their own gates
    always_comb begin
        head_s       = mem_r[rd_ptr_r];
        dec_opcode_s = head_s[17:15];
        dec_dest_s   = head_s[14:11];
        dec_addr1_s  = head_s[10:7];
        dec_addr2_s  = head_s[3:0];
        dec_sign_s   = head_s[6];
        dec_imm_s    = head_s[5:0];
        case (dec_opcode_s)
            OP_LOAD, OP_ADDI, OP_SUBI: begin
                dec_addr2_s = 4'd0;
            end
            OP_ADD, OP_SUB, OP_MUL: begin
                dec_sign_s = 1'b0;
                dec_imm_s  = 6'd0;
            end
            OP_CLEAR: begin
                dec_addr1_s = 4'd0;
                dec_addr2_s = 4'd0;
            end
            OP_DISPLAY: begin
                dec_dest_s = 4'd0;
            end
            default: begin
                dec_dest_s = head_s[14:11];
            end
        endcase
    end

    // Next-state logic, pop request and write-enable cycle counter
    always_comb begin
        state_next_s  = state_r;
        we_cnt_next_s = we_cnt_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_ZERO) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                state_next_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (opcode_r == OP_DISPLAY) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s  = ST_WRITE;
                    we_cnt_next_s = WEC_ZERO;
                end
            end
            ST_WRITE: begin
                if (we_cnt_r == WEC_LAST) begin
                    state_next_s  = ST_RELEASE;
                    we_cnt_next_s = WEC_ZERO;
                end else begin
                    we_cnt_next_s = we_cnt_r + WEC_ONE;
                end
            end
            ST_RELEASE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s  = ST_IDLE;
                we_cnt_next_s = WEC_ZERO;
            end
        endcase
    end

    // Occupancy and pulse qualifiers feeding the registered outputs
    always_comb begin
        count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        disp_next_s  = (state_next_s == ST_EXEC) && (opcode_r == OP_DISPLAY);
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= instr_in;
        end
    end

    // State, pointers and all outputs; outputs are registered from next-cycle values
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= CNT_ZERO;
            we_cnt_r     <= WEC_ZERO;
            opcode_r     <= 3'd0;
            addr1_r      <= 4'd0;
            addr2_r      <= 4'd0;
            dest_r       <= 4'd0;
            sign_r       <= 1'b0;
            imm_r        <= 6'd0;
            we_r         <= 1'b0;
            display_en_r <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            ready_r      <= 1'b1;
        end else begin
            state_r  <= state_next_s;
            we_cnt_r <= we_cnt_next_s;
            count_r  <= count_next_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                opcode_r <= dec_opcode_s;
                addr1_r  <= dec_addr1_s;
                addr2_r  <= dec_addr2_s;
                dest_r   <= dec_dest_s;
                sign_r   <= dec_sign_s;
                imm_r    <= dec_imm_s;
            end
            we_r         <= (state_next_s == ST_WRITE);
            display_en_r <= disp_next_s;
            done_r       <= (state_next_s == ST_RELEASE) || disp_next_s;
            busy_r       <= (state_next_s != ST_IDLE) || (count_next_s != CNT_ZERO);
            ready_r      <= (count_next_s != DEPTH_C);
        end
    end

    assign instr_ready = ready_r;
    assign opcode      = opcode_r;
    assign addr1       = addr1_r;
    assign addr2       = addr2_r;
    assign dest        = dest_r;
    assign sinalImm    = sign_r;
    assign Imm         = imm_r;
    assign we          = we_r;
    assign display_en  = display_en_r;
    assign done        = done_r;
    assign busy        = busy_r;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Control-side initiator for the register-file/ALU block: accepts 18-bit instruction words over a valid/ready handshake and buffers them in a small FIFO.
- Decodes each instruction into the register-file command fields (opcode, addr1, addr2, dest, sinalImm, Imm) and sequences the write enable across a fixed multi-cycle schedule.
- Sits between the instruction source (switch/input front-end) and the register file. Emits a display request for non-writing DISPLAY instructions.

Parameters:
- FIFO_DEPTH, 4, instruction buffer entries (power of 2, ≥2).
- WE_CYCLES, 2, cycles `we` is held high per writing instruction (≥2, so the register file's state machine registers WRITE before release).

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- instr_in  in  18  instruction word
- instr_valid  in  1  instr_in is valid this cycle
- instr_ready  out  1  FIFO can accept (not full)
- opcode  out  3  to register file/ALU
- addr1  out  4  source register 1
- addr2  out  4  source register 2
- dest  out  4  destination register
- sinalImm  out  1  immediate sign bit
- Imm  out  6  immediate magnitude
- we  out  1  register-file write enable
- display_en  out  1  one-cycle pulse for DISPLAY
- done  out  1  one-cycle pulse when an instruction retires
- busy  out  1  sequencer not IDLE or FIFO non-empty

Behaviour:
- Instruction format:
  - [17:15] opcode; [14:11] dest; [10:7] addr1.
  - Register-form ops: [3:0] = addr2, [6:4] ignored.
  - Immediate-form ops: [6] = sinalImm, [5:0] = Imm.
- Opcode map: 000 LOAD (imm), 001 ADD (reg), 010 ADDI (imm), 011 SUB (reg), 100 SUBI (imm), 101 MUL (reg), 110 CLEAR (no sources), 111 DISPLAY (reg addr1, no write).
- Field gating:
  - Immediate-form ops: addr2 = 0.
  - Register-form ops: sinalImm = 0 and Imm = 0.
  - CLEAR: addr1 = addr2 = 0.
  - DISPLAY: dest = 0.
- FIFO:
  - Push when instr_valid && instr_ready. instr_ready = !full.
  - Push on full is dropped, with FIFO unchanged.
  - Pop only in IDLE when non-empty.
  - Push and pop in the same cycle is allowed when full: the pop frees a slot, but instr_ready is still 0 that cycle, so no push occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine (states IDLE, DECODE, EXEC, WRITE, RELEASE):
  - IDLE: if FIFO non-empty, pop into the instruction register, then go to DECODE.
  - DECODE (1 cycle): drive the decoded fields to the outputs; fields stay stable until the next DECODE. Go to EXEC.
  - EXEC (1 cycle): ALU settles.
    - DISPLAY: pulse display_en and done, then go to IDLE.
    - Otherwise: go to WRITE.
  - WRITE: we = 1 for exactly WE_CYCLES cycles (internal counter), then go to RELEASE.
  - RELEASE (1 cycle): we = 0, done pulses, then go to IDLE.
- Latency:
  - Writing instruction pushed into an empty FIFO with the sequencer IDLE: push at cycle 0, popped at cycle 1, DECODE at 2, EXEC at 3, we high at cycles 4–5, done at cycle 6.
  - Throughput: one writing instruction per 2 + WE_CYCLES + 2 cycles.
- we is 0 in every state except WRITE. display_en and done are never high for more than one cycle.
- Reset (synchronous, any state, including mid-WRITE):
  - State = IDLE; FIFO empty with pointers at 0; WE counter = 0.
  - All field outputs = 0; we = 0; display_en = 0; done = 0; busy = 0; instr_ready = 1 on the cycle after rst.
  - A push on a cycle where rst = 1 is ignored.
- An invalid/unused field value has no special case; all 8 opcodes are legal.

Test Plan:
- Reset, then push ADDI 0b010_0011_0001_1_000101 → fields opcode=2, dest=3, addr1=1, sinalImm=1, Imm=5, addr2=0; we high exactly in cycles 4–5 after push; done at cycle 6.
- Push ADD dest=2, addr1=4, addr2=7 → addr2=7, sinalImm=0, Imm=0; we high for 2 cycles; single done pulse.
- Push DISPLAY addr1=9 → display_en pulse in EXEC and done in the same cycle; we never asserted; dest=0.
- Hold instr_valid for 6 back-to-back distinct words while the sequencer is busy → instr_ready drops after the FIFO fills. The first 4 accepted words retire in order and the dropped words never appear. Total done pulses = 4 plus any words accepted once slots free.
- Assert rst for 1 cycle during the second WE cycle → we = 0 and busy = 0 on the next cycle, FIFO empty, no done pulse. The next pushed instruction executes normally.
- Fill the FIFO, drain it, and refill across the pointer wrap (8+ instructions) → in-order retirement, and busy deasserts only after the last done.
